// File: rtl/inst_encoder_loader_if.sv
// Field-tuple stream and instruction-memory write port of the encoder/loader.
// master = tuple producer + memory side (bench), slave = inst_encoder_loader.
interface inst_encoder_loader_if #(
  parameter int ADDR_W = 8
) ();
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_code;
  logic [3:0]        func_code;
  logic [3:0]        rd;
  logic [3:0]        rs1;
  logic [3:0]        rs2;
  logic [15:0]       imm;
  logic              mem_we;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_valid, op_code, func_code, rd, rs1, rs2, imm, mem_ready,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, op_code, func_code, rd, rs1, rs2, imm, mem_ready,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/inst_encoder_loader.sv
// Packs decoded instruction fields into 32-bit words and streams them into instruction memory.
// Optional running checksum of written words when ENC_CHECKSUM_EN is defined.
//
// state | meaning
// IDLE  | waiting for start; no tuples accepted, no writes pending
// RUN   | session active; accepting legal tuples until word_count writes complete
module inst_encoder_loader #(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [ADDR_W:0]       word_count,
  inst_encoder_loader_if.slave  bus,
  output logic                  busy,
  output logic                  done,
`ifdef ENC_CHECKSUM_EN
  output logic                  err_illegal,
  output logic [31:0]           checksum
`else
  output logic                  err_illegal
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   acc_q;
  logic [ADDR_W:0]   wr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic              we_q;
  logic              done_q;
  logic              err_q;

  logic start_ok;
  logic rdy;
  logic in_fire;
  logic legal;
  logic take;
  logic wr_fire;
  logic last_wr;

  function automatic logic is_legal(input logic [3:0] op);
    case (op)
      4'hC, 4'hD, 4'h4, 4'h5, 4'h2, 4'h3, 4'h7, 4'h6: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

  // Register format (op[3]) carries rs2 and zero fill; all others carry the immediate.
  function automatic logic [31:0] encode(input logic [3:0] op, input logic [3:0] fc,
                                         input logic [3:0] d, input logic [3:0] s1,
                                         input logic [3:0] s2, input logic [15:0] im);
    if (op[3]) return {op, fc, d, s1, s2, 12'h000};
    else       return {op, fc, d, s1, im};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start_ok  = 1'b0;
    rdy       = 1'b0;
    wr_fire   = 1'b0;
    last_wr   = 1'b0;
    case (state)
      S_IDLE: begin
        start_ok = start;
        if (start && (word_count != '0)) state_nxt = S_RUN;
      end
      S_RUN: begin
        rdy     = (acc_q < cnt_q) && (!we_q || bus.mem_ready);
        wr_fire = we_q && bus.mem_ready;
        last_wr = wr_fire && ((wr_q + 1'b1) == cnt_q);
        if (last_wr) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign legal   = is_legal(bus.op_code);
  assign in_fire = bus.in_valid && rdy;
  assign take    = in_fire && legal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      wr_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= (start_ok && (word_count == '0)) || last_wr;
      if (start_ok) begin
        cnt_q  <= word_count;
        acc_q  <= '0;
        wr_q   <= '0;
        addr_q <= base_addr;
        err_q  <= 1'b0;
      end else begin
        if (in_fire && !legal) err_q <= 1'b1;
        if (take)              acc_q <= acc_q + 1'b1;
        if (wr_fire) begin
          wr_q   <= wr_q + 1'b1;
          addr_q <= addr_q + 1'b1;
        end
        // One-deep output register: a new word reloads it in the same cycle the old one drains.
        if (take) begin
          we_q    <= 1'b1;
          wdata_q <= encode(bus.op_code, bus.func_code, bus.rd, bus.rs1, bus.rs2, bus.imm);
        end else if (wr_fire) begin
          we_q <= 1'b0;
        end
      end
    end
  end

`ifdef ENC_CHECKSUM_EN
  logic [31:0] cs_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         cs_q <= '0;
    else if (start_ok) cs_q <= '0;
    else if (wr_fire)  cs_q <= {cs_q[30:0], cs_q[31]} ^ wdata_q;
  end

  assign checksum = cs_q;
`endif

  assign bus.in_ready  = rdy;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign busy          = (state == S_RUN);
  assign done          = done_q;
  assign err_illegal   = err_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: directed sessions plus random traffic against a
// transaction-level model (queue of pending words, session counters).
module tb_inst_encoder_loader;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   word_count = '0;
  logic          busy, done, err_illegal;
`ifdef ENC_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  inst_encoder_loader_if #(.ADDR_W(AW)) bus ();

  inst_encoder_loader #(.ADDR_W(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .bus        (bus),
    .busy       (busy),
    .done       (done),
`ifdef ENC_CHECKSUM_EN
    .err_illegal(err_illegal),
    .checksum   (checksum)
`else
    .err_illegal(err_illegal)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  bit          m_busy, m_done, m_err;
  int          m_cnt, m_acc, m_wr, m_addr;
  int unsigned m_cs;
  int unsigned q[$];
  int unsigned log_addr[$];
  int unsigned log_data[$];
  bit          last_took;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input int op);
    return op inside {12, 13, 4, 5, 2, 3, 7, 6};
  endfunction

  function automatic int unsigned m_word(input int op, f, d, s1, s2, im);
    if (op >= 8) return (op << 28) + (f << 24) + (d << 20) + (s1 << 16) + (s2 << 12);
    return (op << 28) + (f << 24) + (d << 20) + (s1 << 16) + im;
  endfunction

  task automatic model_reset();
    q.delete();
    m_busy = 0; m_done = 0; m_err = 0;
    m_cnt = 0; m_acc = 0; m_wr = 0; m_addr = 0; m_cs = 0;
  endtask

  // One clock cycle: drive at negedge, check against the model, advance the model over the edge.
  task automatic step(input bit st, input bit iv, input bit mr,
                      input logic [3:0] op, input logic [3:0] f, input logic [3:0] d,
                      input logic [3:0] s1, input logic [3:0] s2, input logic [15:0] im);
    bit exp_rdy, nd;
    @(negedge clk);
    start = st; bus.in_valid = iv; bus.mem_ready = mr;
    bus.op_code = op; bus.func_code = f; bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im;
    #1;
    exp_rdy = m_busy && (m_acc < m_cnt) && (q.size() == 0 || mr);
    chk("busy", busy, m_busy);
    chk("in_ready", bus.in_ready, exp_rdy);
    chk("mem_we", bus.mem_we, q.size() > 0);
    if (q.size() > 0) begin
      chk("mem_addr", bus.mem_addr, m_addr);
      chk("mem_wdata", bus.mem_wdata, q[0]);
    end
    chk("done", done, m_done);
    chk("err_illegal", err_illegal, m_err);
`ifdef ENC_CHECKSUM_EN
    chk("checksum", checksum, m_cs);
`endif
    if (bus.mem_we === 1'b1 && mr) begin
      log_addr.push_back(bus.mem_addr);
      log_data.push_back(bus.mem_wdata);
    end
    nd = 0;
    last_took = iv && exp_rdy;
    if (st && !m_busy) begin
      m_err = 0; m_addr = base_addr; m_acc = 0; m_wr = 0; m_cnt = word_count; m_cs = 0;
      if (word_count == 0) nd = 1; else m_busy = 1;
    end else if (m_busy) begin
      if (q.size() > 0 && mr) begin
        int unsigned w;
        w = q.pop_front();
        m_cs = ((m_cs << 1) | (m_cs >> 31)) ^ w;
        m_addr = (m_addr + 1) % (1 << AW);
        m_wr++;
        if (m_wr == m_cnt) begin m_busy = 0; nd = 1; end
      end
      if (last_took) begin
        if (m_legal(op)) begin q.push_back(m_word(op, f, d, s1, s2, im)); m_acc++; end
        else m_err = 1;
      end
    end
    m_done = nd;
  endtask

  task automatic idle_step(input bit mr);
    step(0, 0, mr, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic begin_session(input int b, input int c);
    base_addr = b[AW-1:0]; word_count = c[AW:0];
    log_addr.delete(); log_data.delete();
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic feed(input logic [3:0] op, f, d, s1, s2, input logic [15:0] im,
                      output int tries);
    tries = 0;
    last_took = 0;
    while (!last_took && tries < 20) begin
      step(0, 1, 1, op, f, d, s1, s2, im);
      tries++;
    end
    chk("feed_timeout", last_took, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((m_busy || m_done) && n < 50) begin
      idle_step(1);
      n++;
    end
    chk("drain_timeout", n < 50, 1);
  endtask

  initial begin
    int t0, t1, t2;
    model_reset();
    bus.in_valid = 0; bus.mem_ready = 0;
    bus.op_code = 0; bus.func_code = 0; bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0;

    #2;
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_mem_addr", bus.mem_addr, 0);
    chk("rst_mem_wdata", bus.mem_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_illegal, 0);
    @(negedge clk); reset = 0;

    // Register-format ADD: imm ignored
    begin_session(8'h10, 1);
    feed(4'hC, 4'h7, 4'h1, 4'h2, 4'h4, 16'hFFFF, t0);
    drain();
    chk("add_count", log_data.size(), 1);
    if (log_data.size() == 1) begin
      chk("add_data", log_data[0], 32'hC7124000);
      chk("add_addr", log_addr[0], 32'h10);
    end

    // Immediate formats back to back at full rate
    begin_session(8'h20, 3);
    feed(4'h4, 4'h7, 4'h1, 4'h2, 4'hA, 16'hFFFF, t0);
    feed(4'h7, 4'h0, 4'h1, 4'h2, 4'hA, 16'hFFFF, t1);
    feed(4'h6, 4'h0, 4'h1, 4'h2, 4'hA, 16'hFFFF, t2);
    chk("thru_tries", t0 + t1 + t2, 3);
    drain();
    chk("imm_count", log_data.size(), 3);
    if (log_data.size() == 3) begin
      chk("addi_data", log_data[0], 32'h4712FFFF);
      chk("lw_data", log_data[1], 32'h7012FFFF);
      chk("jal_data", log_data[2], 32'h6012FFFF);
      chk("jal_addr", log_addr[2], 32'h22);
    end

    // Backpressure on the first word
    begin_session(8'h30, 2);
    feed(4'h5, 4'h3, 4'h9, 4'h8, 4'h0, 16'h1234, t0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 4'hD, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0);
    feed(4'hD, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0, t0);
    drain();
    chk("bp_count", log_data.size(), 2);
    if (log_data.size() == 2) begin
      chk("bp_data0", log_data[0], 32'h53981234);
      chk("bp_data1", log_data[1], 32'hD1234000);
      chk("bp_addr1", log_addr[1], 32'h31);
    end

    // Illegal opcode dropped mid-session
    begin_session(8'h40, 2);
    feed(4'h2, 4'h1, 4'h1, 4'h1, 4'h0, 16'h00AA, t0);
    feed(4'h0, 4'h5, 4'h5, 4'h5, 4'h5, 16'h5555, t0);
    idle_step(1);
    chk("ill_busy", busy, 1);
    feed(4'h3, 4'h2, 4'h2, 4'h2, 4'h0, 16'h00BB, t0);
    drain();
    chk("ill_err", err_illegal, 1);
    chk("ill_count", log_data.size(), 2);

    // Address wrap
    begin_session(8'hFF, 2);
    feed(4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0001, t0);
    feed(4'h4, 4'h0, 4'h0, 4'h0, 4'h0, 16'h0002, t0);
    drain();
    chk("wrap_count", log_addr.size(), 2);
    if (log_addr.size() == 2) begin
      chk("wrap_addr0", log_addr[0], 32'hFF);
      chk("wrap_addr1", log_addr[1], 32'h00);
    end
    chk("err_cleared", err_illegal, 0);

`ifdef ENC_CHECKSUM_EN
    begin_session(8'h50, 2);
    feed(4'hC, 4'h7, 4'h1, 4'h2, 4'h4, 16'hFFFF, t0);
    feed(4'h4, 4'h7, 4'h1, 4'h2, 4'h0, 16'hFFFF, t0);
    drain();
    chk("checksum_val", checksum, 32'hC9367FFE);
`endif

    // Zero-length session
    begin_session(8'h77, 0);
    chk("zero_done_pending", m_done, 1);
    drain();
    chk("zero_count", log_data.size(), 0);

    // Start while busy is ignored
    begin_session(8'h60, 2);
    feed(4'h6, 4'h1, 4'h1, 4'h1, 4'h1, 16'h0101, t0);
    base_addr = 8'h99; word_count = 9'd5;
    step(1, 0, 1, 0, 0, 0, 0, 0, 0);
    feed(4'h6, 4'h2, 4'h2, 4'h2, 4'h2, 16'h0202, t0);
    drain();
    chk("busy_start_count", log_addr.size(), 2);
    if (log_addr.size() == 2) chk("busy_start_addr1", log_addr[1], 32'h61);

    // Random sessions
    for (int s = 0; s < 20; s++) begin
      int n;
      begin_session($urandom_range(0, 255), $urandom_range(1, 6));
      n = 0;
      while (m_busy && n < 300) begin
        step(0, $urandom_range(0, 1), ($urandom_range(0, 3) != 0),
             4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             16'($urandom));
        n++;
      end
      chk("rand_timeout", n < 300, 1);
      drain();
      chk("rand_count", log_data.size(), m_cnt);
    end

    // Reset with a write pending
    begin_session(8'h80, 3);
    feed(4'h7, 4'h7, 4'h7, 4'h7, 4'h7, 16'h7777, t0);
    idle_step(0);
    chk("pre_rst_we", bus.mem_we, 1);
    @(negedge clk); reset = 1; #1;
    chk("mid_rst_we", bus.mem_we, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", bus.mem_addr, 0);
    chk("mid_rst_wdata", bus.mem_wdata, 0);
    chk("mid_rst_ready", bus.in_ready, 0);
    model_reset();
    @(negedge clk); reset = 0;
    begin_session(8'h90, 1);
    feed(4'hD, 4'h0, 4'h3, 4'h4, 4'h5, 16'h0, t0);
    drain();
    chk("post_rst_count", log_data.size(), 1);
    if (log_data.size() == 1) chk("post_rst_data", log_data[0], 32'hD0345000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/inst_encoder_loader.md
# inst_encoder_loader

Packs decoded instruction fields (op_code, func_code, rd, rs1, rs2, imm) back into 32-bit instruction words and streams them into instruction memory through a write port. It is the inverse of the instruction decoder: it is used by the program loader and self-test path to fill instruction memory before the pipelined CPU is released from reset. Each loading session is bounded by a base address and a word count. Field tuples arrive on a valid/ready handshake, and memory writes use a second valid/ready handshake.

## Interface
- ADDR_W, 8: instruction memory word-address width.
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous reset, active-high.
- start  in  1  one-cycle pulse; begins a session. Ignored while busy.
- base_addr  in  ADDR_W  first write address; sampled on start.
- word_count  in  ADDR_W+1  number of legal words to write; sampled on start. Range 0..2^ADDR_W.
- in_valid  in  1  field tuple present.
- in_ready  out  1  tuple accepted on a clock edge where in_valid && in_ready.
- op_code, func_code, rd, rs1, rs2  in  4 each  instruction fields.
- imm  in  16  immediate field.
- mem_we  out  1  write request (valid).
- mem_ready  in  1  memory accepts the write on a clock edge where mem_we && mem_ready.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  32  encoded instruction.
- busy  out  1  session active.
- done  out  1  one-cycle pulse at session end.
- err_illegal  out  1  sticky; set when an illegal opcode is received, cleared by start or reset.
- checksum  out  32  present only with ENC_CHECKSUM_EN.

## Operation
- Encoding: word[31:28]=op_code, [27:24]=func_code, [23:20]=rd, [19:16]=rs1.
- Register format, op_code[3]==1 (1100 ALU-R, 1101 CMP-R): [15:12]=rs2, [11:0]=0. The imm input is ignored.
- Immediate format, otherwise: [15:0]=imm. The rs2 input is ignored.
- Legal opcodes: 1100, 1101, 0100, 0101, 0010, 0011, 0111, 0110.
- Illegal tuple: the handshake still completes. The tuple is dropped, err_illegal is set, and the tuple does not count toward word_count.
- FSM states:
  - IDLE → RUN on start with word_count>0.
  - start with word_count==0: done pulses the next cycle and the FSM stays in IDLE.
  - RUN → IDLE on the write handshake that completes word_count writes; done pulses in the following cycle.
- Counters:
  - accepted: legal tuples taken.
  - written: write handshakes completed.
  - mem_addr: loads base_addr on start and increments by 1 after each write handshake, wrapping modulo 2^ADDR_W.
- Output register is one entry deep:
  - in_ready = RUN && accepted<word_count && (!mem_we || mem_ready).
  - When a legal tuple is accepted, mem_we is set and mem_wdata is loaded.
  - When a write handshake completes and no new legal tuple is accepted in the same cycle, mem_we clears.
- mem_wdata and mem_addr hold stable while mem_we && !mem_ready.
- busy = (state==RUN).

## Timing
- Reset values: in_ready 0, mem_we 0, mem_addr 0, mem_wdata 0, busy 0, done 0, err_illegal 0, checksum 0, FSM in IDLE.
- Latency: tuple accepted at edge N → mem_we=1 with the encoded word during cycle N+1.
- Throughput: 1 word/cycle while mem_ready=1.
- Simultaneous write handshake and new acceptance in the same cycle: the register reloads with no bubble.
- Reset mid-session: outputs return to reset values immediately. A pending write is abandoned, not completed.
- done is never asserted in the same cycle as mem_we for that session's last word.

## Configuration
- ENC_CHECKSUM_EN defined:
  - checksum clears on start.
  - On each write handshake, checksum becomes {checksum[30:0],checksum[31]} ^ mem_wdata.
  - checksum is valid when done pulses and holds until the next start.
- ENC_CHECKSUM_EN undefined: the checksum port and its logic are absent.

## Test plan
- ADD: base 0x10, count 1, tuple C,7,1,2,4, imm=0xFFFF → one write of 0xC7124000 at 0x10, then done.
- ADDI/LW/JAL: tuples 4,7,1,2,x,0xFFFF; 7,0,1,2,x,0xFFFF; 6,0,1,2,x,0xFFFF → 0x4712FFFF, 0x7012FFFF, 0x6012FFFF at consecutive addresses, 1 per cycle with mem_ready held 1.
- Backpressure: mem_ready=0 for 3 cycles on the first word → mem_addr and mem_wdata stable, in_ready=0; no words lost or duplicated after release.
- Illegal opcode 0x0 inside a count-2 session → err_illegal=1, the tuple is not written, and the session ends only after 2 legal words.
- Wrap and reset: ADDR_W=8, base 0xFF, count 2 → writes at 0xFF then 0x00. Reset asserted with a write pending → mem_we=0 and busy=0 immediately.
- ENC_CHECKSUM_EN: words 0xC7124000, 0x4712FFFF → checksum 0xC7124000 rotated left 1 (0x8E248001) XOR 0x4712FFFF = 0xC9367FFE.
